uart_receiver: RTL and testbench
================================

# uart_receiver

UART receive engine: the receive-side counterpart of the UART transmitter. It recovers 8N1 frames (LSB first) from the serial `rx` line, samples each bit at mid-bit, and writes each good byte into the receive FIFO with a one-cycle strobe. Error flags (framing, overrun, optional parity) are sticky, and software or DMA clears them. `dma_rxend` gives the same idle/busy indication to DMA that `dma_txend` gives on the transmit side.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Legal values are 4 and above.
- `HALF_BIT`, default `CLKS_PER_BIT/2`: cycles from start-edge detect to the start-bit sample.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `rx`  in  1  asynchronous serial input. The line idles high.
- `fifo_full`  in  1  receive FIFO full. Any write attempted while this is high is dropped.
- `err_clr`  in  1  one-cycle pulse that clears all sticky error flags.
- `pc_r`  out  8  last received byte. Holds its value until the next write.
- `rx_wr`  out  1  one-cycle FIFO write strobe. `pc_r` is valid while it is high.
- `dma_rxend`  out  1  1 when no frame is in progress, 0 while a frame is being received.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun_err`  out  1  sticky: a good byte was dropped because `fifo_full` was high.
- `parity_err`  out  1  sticky parity error. Tied to 0 unless `RX_PARITY_EN` is defined.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized signal, `rx_s`.
- **Bit counter:** width is `$clog2(CLKS_PER_BIT)`. Bit index is 0..7.
- **States:**
  - `RX_IDLE`: when `rx_s`=0, clear the counter, set `dma_rxend`=0, go to `RX_START`.
  - `RX_START`: count to `HALF_BIT`-1, then sample. If `rx_s`=0, go to `RX_DATA` with index 0. If `rx_s`=1 (glitch), go to `RX_IDLE`, set `dma_rxend`=1, and flag nothing.
  - `RX_DATA`: every `CLKS_PER_BIT` cycles, shift `rx_s` into bit [index]. After bit 7, go to `RX_PARITY` if the macro is defined, otherwise to `RX_STOP`.
  - `RX_PARITY` (macro only): after `CLKS_PER_BIT` cycles, sample the parity bit and compare it against even parity of the data.
  - `RX_STOP`: after `CLKS_PER_BIT` cycles, sample the stop bit.
    - Stop = 1 and no parity error, `fifo_full`=0: write the byte, go to `RX_IDLE`.
    - Stop = 1 and no parity error, `fifo_full`=1: set `overrun_err`, leave `pc_r` unchanged, go to `RX_IDLE`.
    - Stop = 1 with a parity error: set `parity_err`, write nothing, go to `RX_IDLE`.
    - Stop = 0: set `frame_err`, write nothing, go to `RX_WAIT`.
  - `RX_WAIT`: hold until `rx_s`=1, then go to `RX_IDLE`. A line held low (break) therefore never re-triggers a frame.
- **`dma_rxend`:** returns to 1 in the same cycle the FSM re-enters `RX_IDLE`.
- **Illegal state encodings:** go to `RX_IDLE` and clear the counter.
- **Error flags:** if `err_clr` and a new error set occur in the same cycle, the set wins.

## Timing
- **Reset values:**
  - Outputs: `pc_r`=0x00, `rx_wr`=0, `dma_rxend`=1, `frame_err`=0, `overrun_err`=0, `parity_err`=0.
  - Internal: FSM in `RX_IDLE`, synchronizer flops = 1, counter = 0.
- **Reset mid-frame:** the partial byte is discarded. Reset is honored in any state.
- **Start detect:** 2 cycles after the `rx` falling edge, due to the synchronizer.
- **Sample points (cycles after start detect):**
  - start bit: `HALF_BIT`
  - data bit n: `HALF_BIT` + (n+1)·`CLKS_PER_BIT`
  - stop bit: `HALF_BIT` + 9·`CLKS_PER_BIT`, or +10·`CLKS_PER_BIT` with parity.
- **Write timing:** `rx_wr` and the new `pc_r` appear in the cycle after the stop sample. `rx_wr` is high for exactly 1 cycle.
- **Back-to-back frames:** the FSM is in `RX_IDLE` half a bit before the stop bit ends, so a following start bit is caught with no gap.
- **Error flags:** set in the cycle after the sample that detects the error.

## Configuration
- `RX_PARITY_EN` defined:
  - Frame is 8E1 (11 bits); `RX_PARITY` state is compiled in.
  - A parity mismatch sets `parity_err` and suppresses the write.
- `RX_PARITY_EN` undefined:
  - Frame is 8N1 (10 bits); no parity state.
  - `parity_err` is constant 0.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=868, send 0xA5 → exactly one `rx_wr` pulse with `pc_r`=0xA5. `dma_rxend` is 0 during the frame and returns to 1 mid-stop-bit. No error flags set.
- **Start glitch:** `rx` low for 300 cycles, then high → no `rx_wr`, FSM returns to `RX_IDLE`. A following 0x3C is received correctly.
- **Framing error and break:** send 0x3C with stop bit = 0, then hold `rx` low for 5 bit times → `frame_err`=1, no `rx_wr`, no re-trigger while low. After `rx` goes high, `err_clr` clears `frame_err`. On the cycle where `err_clr` coincides with a new error, `frame_err` stays 1.
- **Overrun:** receive 0x12, then 0x55 with `fifo_full`=1 → no second `rx_wr`, `pc_r` stays 0x12, `overrun_err`=1.
- **Back-to-back and reset:** send 0x00 then 0xFF with no idle gap → two `rx_wr` pulses with 0x00 then 0xFF. Assert `rst` during data bit 4 of 0x81 → all outputs return to reset values. Resend 0x81 → received correctly.
- **Parity (`RX_PARITY_EN`):** send 0x07 with parity bit 0 → `parity_err`=1, no `rx_wr`. Resend 0x07 with parity bit 1 → written with `pc_r`=0x07.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive engine for 8N1 frames (LSB first).
// The rx line is synchronized, each bit is sampled at mid-bit, and every good
// byte is presented on pc_r with a one-cycle rx_wr strobe into the receive FIFO.
// Framing, overrun and (optionally) parity errors are sticky until err_clr.
// Optional feature macro: RX_PARITY_EN -- when defined, frames are 8E1 and a
// parity mismatch sets parity_err and suppresses the write; when undefined,
// frames are 8N1 and parity_err is constant 0.

module uart_receiver #(
   parameter int CLKS_PER_BIT = 868,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       fifo_full,
   input  logic       err_clr,
   output logic [7:0] pc_r,
   output logic       rx_wr,
   output logic       dma_rxend,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_STOP   = 3'd3,
      RX_WAIT   = 3'd4
`ifdef RX_PARITY_EN
      ,
      RX_PARITY = 3'd5
`endif
   } rx_state_t;

   rx_state_t        state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       idx_r;
   logic [7:0]       shift_r;
   logic             sync1_r;
   logic             rx_s;

`ifdef RX_PARITY_EN
   logic             par_bad_r;
   logic             par_err_r;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

   assign parity_err = par_err_r;
`else
   assign parity_err = 1'b0;
`endif

   // Two-flop synchronizer for the asynchronous rx line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync1_r <= rx;
         rx_s    <= sync1_r;
      end
   end

   // Receive FSM: bit timing, byte assembly, write strobe and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= RX_IDLE;
         cnt_r       <= '0;
         idx_r       <= 3'd0;
         shift_r     <= 8'h00;
         pc_r        <= 8'h00;
         rx_wr       <= 1'b0;
         dma_rxend   <= 1'b1;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef RX_PARITY_EN
         par_bad_r   <= 1'b0;
         par_err_r   <= 1'b0;
`endif
      end else begin
         rx_wr <= 1'b0;

         // Clear first so that an error set later in this cycle takes priority.
         if (err_clr) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
         end

         case (state_r)
            RX_IDLE: begin
               if (!rx_s) begin
                  cnt_r     <= '0;
                  dma_rxend <= 1'b0;
                  state_r   <= RX_START;
               end
            end

            RX_START: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r <= '0;
                  if (!rx_s) begin
                     idx_r   <= 3'd0;
                     state_r <= RX_DATA;
                  end else begin
                     // Too short to be a start bit: drop it silently.
                     dma_rxend <= 1'b1;
                     state_r   <= RX_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

            RX_DATA: begin
               if (cnt_r == BIT_LAST) begin
                  cnt_r          <= '0;
                  shift_r[idx_r] <= rx_s;
                  if (idx_r == 3'd7) begin
`ifdef RX_PARITY_EN
                     state_r <= RX_PARITY;
`else
                     state_r <= RX_STOP;
`endif
                  end else begin
                     idx_r <= idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

`ifdef RX_PARITY_EN
            RX_PARITY: begin
               if (cnt_r == BIT_LAST) begin
                  cnt_r     <= '0;
                  par_bad_r <= (rx_s != even_parity(shift_r));
                  state_r   <= RX_STOP;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
`endif

            RX_STOP: begin
               if (cnt_r == BIT_LAST) begin
                  cnt_r <= '0;
                  if (rx_s) begin
                     // Back to idle mid-stop-bit so a following start bit is caught.
                     dma_rxend <= 1'b1;
                     state_r   <= RX_IDLE;
`ifdef RX_PARITY_EN
                     if (par_bad_r) begin
                        par_err_r <= 1'b1;
                     end else if (fifo_full) begin
                        overrun_err <= 1'b1;
                     end else begin
                        pc_r  <= shift_r;
                        rx_wr <= 1'b1;
                     end
`else
                     if (fifo_full) begin
                        overrun_err <= 1'b1;
                     end else begin
                        pc_r  <= shift_r;
                        rx_wr <= 1'b1;
                     end
`endif
                  end else begin
                     frame_err <= 1'b1;
                     state_r   <= RX_WAIT;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

            RX_WAIT: begin
               // A held-low line (break) must not look like a new start bit.
               if (rx_s) begin
                  dma_rxend <= 1'b1;
                  state_r   <= RX_IDLE;
               end
            end

            default: begin
               cnt_r     <= '0;
               dma_rxend <= 1'b1;
               state_r   <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: a full-rate instance (868 clocks/bit) for the
// single-byte timing check and a fast instance (16 clocks/bit) for tables,
// hand-written corner cases and randomized frames against a frame-level model.

module tb_uart_receiver;

   localparam int BCPB  = 868;
   localparam int BHALF = 434;
   localparam int FCPB  = 16;
   localparam int FHALF = 8;
`ifdef RX_PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int NB  = 11;
`else
   localparam bit PAR = 1'b0;
   localparam int NB  = 10;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rx_b, rx_f, fifo_full, err_clr, b_full, b_clr;
   logic [7:0] b_pc, f_pc;
   logic       b_wr, b_dma, b_fe, b_ov, b_pe;
   logic       f_wr, f_dma, f_fe, f_ov, f_pe;

   uart_receiver #(.CLKS_PER_BIT(BCPB), .HALF_BIT(BHALF)) u_slow (
      .clk(clk), .rst(rst), .rx(rx_b), .fifo_full(b_full), .err_clr(b_clr),
      .pc_r(b_pc), .rx_wr(b_wr), .dma_rxend(b_dma), .frame_err(b_fe),
      .overrun_err(b_ov), .parity_err(b_pe));

   uart_receiver #(.CLKS_PER_BIT(FCPB), .HALF_BIT(FHALF)) u_fast (
      .clk(clk), .rst(rst), .rx(rx_f), .fifo_full(fifo_full), .err_clr(err_clr),
      .pc_r(f_pc), .rx_wr(f_wr), .dma_rxend(f_dma), .frame_err(f_fe),
      .overrun_err(f_ov), .parity_err(f_pe));

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int frame_c = 0;
   int f_wr_cnt = 0;
   int b_wr_cnt = 0;
   int b_wr_cyc = 0;
   logic [7:0] b_wr_byte = 8'h00;
   logic f_wr_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Count write strobes on the fast instance and check they last one cycle.
   always @(negedge clk) begin
      if (f_wr) begin
         chk("rx_wr_width", 32'(f_wr_prev), 32'd0);
         f_wr_cnt++;
      end
      f_wr_prev = f_wr;
   end

   // Record write strobes on the full-rate instance.
   always @(negedge clk) begin
      if (b_wr) begin
         b_wr_cnt++;
         b_wr_cyc = cyc;
         b_wr_byte = b_pc;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit big, input logic v);
      if (big) rx_b = v;
      else rx_f = v;
   endtask

   // Serialize one frame: start, 8 data bits LSB first, optional parity, stop.
   task automatic send_frame(input bit big, input logic [7:0] d, input logic stop, input logic pbit);
      int cpb;
      logic seq [11];
      cpb = big ? BCPB : FCPB;
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[i+1] = d[i];
      if (PAR) begin
         seq[9]  = pbit;
         seq[10] = stop;
      end else begin
         seq[9]  = stop;
         seq[10] = 1'b1;
      end
      frame_c = cyc;
      for (int i = 0; i < NB; i++) begin
         drive(big, seq[i]);
         step(cpb);
      end
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       full;
      int         gap;
      int         exp_wr;
      logic [7:0] exp_pc;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t tbl [6];

   // Frame-level reference state for the randomized section.
   logic [7:0] m_pc;
   logic       m_fe, m_ov, m_pe;

   initial begin
      int w0;
      logic [7:0] d;
      logic stop, full, pbit, par_ok, good;
      int gap;

      tbl[0] = '{8'h3C, 1'b1, 1'b0, 1, 1, 8'h3C, 1'b0, 1'b0};
      tbl[1] = '{8'h12, 1'b1, 1'b0, 1, 1, 8'h12, 1'b0, 1'b0};
      tbl[2] = '{8'h55, 1'b1, 1'b1, 1, 0, 8'h12, 1'b0, 1'b1};
      tbl[3] = '{8'h3C, 1'b0, 1'b0, 2, 0, 8'h12, 1'b1, 1'b0};
      tbl[4] = '{8'h00, 1'b1, 1'b0, 0, 1, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'hFF, 1'b1, 1'b0, 1, 1, 8'hFF, 1'b0, 1'b0};

      rst = 1'b1; rx_b = 1'b1; rx_f = 1'b1; fifo_full = 1'b0; err_clr = 1'b0;
      b_full = 1'b0; b_clr = 1'b0;
      step(3);
      chk("rst_pc", 32'(f_pc), 32'h00);
      chk("rst_wr", 32'(f_wr), 32'd0);
      chk("rst_dma", 32'(f_dma), 32'd1);
      chk("rst_fe", 32'(f_fe), 32'd0);
      chk("rst_ov", 32'(f_ov), 32'd0);
      chk("rst_pe", 32'(f_pe), 32'd0);
      rst = 1'b0;
      step(2);

      // Single byte at full rate, with exact write timing and busy window.
      fork
         send_frame(1'b1, 8'hA5, 1'b1, ^8'hA5);
         begin
            step(5 * BCPB);
            chk("slow_busy_mid", 32'(b_dma), 32'd0);
            step(3 + BHALF + (NB - 1) * BCPB - 5 - 5 * BCPB);
            chk("slow_busy_late", 32'(b_dma), 32'd0);
            step(10);
            chk("slow_idle_stop", 32'(b_dma), 32'd1);
         end
      join
      chk("slow_wr_cnt", 32'(b_wr_cnt), 32'd1);
      chk("slow_byte", 32'(b_wr_byte), 32'hA5);
      chk("slow_pc", 32'(b_pc), 32'hA5);
      chk("slow_wr_cyc", 32'(b_wr_cyc), 32'(frame_c + 3 + BHALF + (NB - 1) * BCPB));
      chk("slow_flags", 32'({b_fe, b_ov, b_pe}), 32'd0);

      // Table-driven frames on the fast instance.
      for (int i = 0; i < 6; i++) begin
         w0 = f_wr_cnt;
         fifo_full = tbl[i].full;
         send_frame(1'b0, tbl[i].d, tbl[i].stop, ^tbl[i].d);
         chk($sformatf("tbl%0d_wr", i), 32'(f_wr_cnt - w0), 32'(tbl[i].exp_wr));
         chk($sformatf("tbl%0d_pc", i), 32'(f_pc), 32'(tbl[i].exp_pc));
         chk($sformatf("tbl%0d_fe", i), 32'(f_fe), 32'(tbl[i].exp_fe));
         chk($sformatf("tbl%0d_ov", i), 32'(f_ov), 32'(tbl[i].exp_ov));
         chk($sformatf("tbl%0d_pe", i), 32'(f_pe), 32'd0);
         if (tbl[i].gap > 0) begin
            rx_f = 1'b1;
            step(tbl[i].gap * FCPB);
            chk($sformatf("tbl%0d_dma", i), 32'(f_dma), 32'd1);
            pulse_clr();
            chk($sformatf("tbl%0d_clr", i), 32'({f_fe, f_ov, f_pe}), 32'd0);
         end
      end
      fifo_full = 1'b0;

      // Start glitch shorter than half a bit is ignored.
      w0 = f_wr_cnt;
      rx_f = 1'b0;
      step(4);
      rx_f = 1'b1;
      step(3 * FCPB);
      chk("glitch_wr", 32'(f_wr_cnt - w0), 32'd0);
      chk("glitch_dma", 32'(f_dma), 32'd1);
      chk("glitch_fe", 32'(f_fe), 32'd0);
      send_frame(1'b0, 8'h3C, 1'b1, ^8'h3C);
      chk("glitch_next_wr", 32'(f_wr_cnt - w0), 32'd1);
      chk("glitch_next_pc", 32'(f_pc), 32'h3C);
      step(FCPB);

      // Framing error followed by a break.
      w0 = f_wr_cnt;
      send_frame(1'b0, 8'h3C, 1'b0, ^8'h3C);
      step(5 * FCPB);
      chk("break_fe", 32'(f_fe), 32'd1);
      chk("break_wr", 32'(f_wr_cnt - w0), 32'd0);
      rx_f = 1'b1;
      step(2 * FCPB);
      chk("break_no_retrigger", 32'(f_wr_cnt - w0), 32'd0);
      chk("break_dma", 32'(f_dma), 32'd1);
      pulse_clr();
      chk("break_clr", 32'(f_fe), 32'd0);

      // err_clr in the same cycle as a new framing error: the set wins.
      fork
         send_frame(1'b0, 8'h3C, 1'b0, ^8'h3C);
         begin
            step(2 + FHALF + (NB - 1) * FCPB);
            pulse_clr();
         end
      join
      chk("clr_vs_set", 32'(f_fe), 32'd1);
      rx_f = 1'b1;
      step(FCPB);

      // Reset during data bit 4 of 0x81.
      d = 8'h81;
      rx_f = 1'b0;
      step(FCPB);
      for (int i = 0; i < 4; i++) begin
         rx_f = d[i];
         step(FCPB);
      end
      rx_f = d[4];
      step(FCPB / 2);
      chk("rst_mid_busy", 32'(f_dma), 32'd0);
      rst = 1'b1;
      rx_f = 1'b1;
      step(2);
      chk("rst_mid_pc", 32'(f_pc), 32'h00);
      chk("rst_mid_wr", 32'(f_wr), 32'd0);
      chk("rst_mid_dma", 32'(f_dma), 32'd1);
      chk("rst_mid_flags", 32'({f_fe, f_ov, f_pe}), 32'd0);
      rst = 1'b0;
      step(2 * FCPB);
      w0 = f_wr_cnt;
      send_frame(1'b0, 8'h81, 1'b1, ^8'h81);
      chk("rst_resend_wr", 32'(f_wr_cnt - w0), 32'd1);
      chk("rst_resend_pc", 32'(f_pc), 32'h81);
      step(FCPB);

`ifdef RX_PARITY_EN
      // Wrong parity then correct parity for 0x07.
      w0 = f_wr_cnt;
      send_frame(1'b0, 8'h07, 1'b1, 1'b0);
      chk("par_bad_pe", 32'(f_pe), 32'd1);
      chk("par_bad_wr", 32'(f_wr_cnt - w0), 32'd0);
      step(FCPB);
      pulse_clr();
      send_frame(1'b0, 8'h07, 1'b1, 1'b1);
      chk("par_ok_wr", 32'(f_wr_cnt - w0), 32'd1);
      chk("par_ok_pc", 32'(f_pc), 32'h07);
      chk("par_ok_pe", 32'(f_pe), 32'd0);
      step(FCPB);
`endif

      // Randomized frames against the frame-level model.
      m_pc = f_pc;
      m_fe = f_fe; m_ov = f_ov; m_pe = f_pe;
      for (int k = 0; k < 40; k++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         full = ($urandom_range(0, 3) == 0);
         pbit = (^d) ^ (PAR && ($urandom_range(0, 4) == 0));
         gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         par_ok = !PAR || (pbit == ^d);
         good = stop && par_ok;
         if (!stop) m_fe = 1'b1;
         if (stop && !par_ok) m_pe = 1'b1;
         if (good && full) m_ov = 1'b1;
         if (good && !full) m_pc = d;
         w0 = f_wr_cnt;
         fifo_full = full;
         send_frame(1'b0, d, stop, pbit);
         chk($sformatf("rnd%0d_wr", k), 32'(f_wr_cnt - w0), 32'(good && !full));
         chk($sformatf("rnd%0d_pc", k), 32'(f_pc), 32'(m_pc));
         chk($sformatf("rnd%0d_flags", k), 32'({f_fe, f_ov, f_pe}), 32'({m_fe, m_ov, m_pe}));
         if (gap > 0) begin
            rx_f = 1'b1;
            step(gap * FCPB);
            pulse_clr();
            m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
         end
      end
      fifo_full = 1'b0;
      rx_f = 1'b1;
      step(FCPB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
